// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory backend between the fetch stage and the
// memory stage, with one outstanding access, fetch starvation protection and flush.
module mem_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int STARVE_MAX = 4,
   parameter int CW         = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          if_stall,
   input  logic          dm_req,
   input  logic          dm_wr,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_valid,
   output logic          dm_stall,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] starve_cnt;
   logic          kill;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          lat_wr;
   logic          forced;
   logic          grant_i;
   logic          grant_d;

   // A flush suppresses a fetch grant, which lets data through even when fetch is forced.
   assign forced  = (starve_cnt == CW'(STARVE_MAX));
   assign grant_i = (state == IDLE) & if_req & ~if_flush & (~dm_req | forced);
   assign grant_d = (state == IDLE) & dm_req & ~grant_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_wr    = lat_wr;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      if_valid  = 1'b0;
      dm_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d) begin
               mem_en    = 1'b1;
               mem_wr    = dm_wr;
               mem_addr  = dm_addr;
               mem_wdata = dm_wdata;
               state_nxt = BUSY_D;
            end else if (grant_i) begin
               mem_en    = 1'b1;
               mem_wr    = 1'b0;
               mem_addr  = if_addr;
               mem_wdata = '0;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I: begin
            if (mem_done) begin
               if_valid  = ~kill & ~if_flush;
               state_nxt = IDLE;
            end
         end
         BUSY_D: begin
            if (mem_done) begin
               dm_valid  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign if_rdata = if_valid ? mem_rdata : '0;
   assign dm_rdata = dm_valid ? mem_rdata : '0;
   assign if_stall = if_req & ~if_valid;
   assign dm_stall = dm_req & ~dm_valid;

   // The issued request is captured so requester changes during BUSY cannot disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wr    <= 1'b0;
      end else if (mem_en) begin
         lat_addr  <= mem_addr;
         lat_wdata <= mem_wdata;
         lat_wr    <= mem_wr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d && if_req && !forced) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // kill remembers a redirect so the eventual completion of the stale fetch is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kill <= 1'b0;
      end else if (state == BUSY_I) begin
         if (mem_done) begin
            kill <= 1'b0;
         end else if (if_flush) begin
            kill <= 1'b1;
         end
      end else begin
         kill <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (state == IDLE && mem_done) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fetch, collision, starvation,
// flush handling, spurious done and mid-access reset.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   logic          dm_req;
   logic          dm_wr;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic          dm_stall;
   logic          mem_en;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic          err;

   int compare_count;
   int mismatch_count;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .CW(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the flow below stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq,
                                input logic dwr, input logic [AW-1:0] daddr, input logic [DW-1:0] dwdata);
      if_req   = ireq;
      if_addr  = iaddr;
      dm_req   = dreq;
      dm_wr    = dwr;
      dm_addr  = daddr;
      dm_wdata = dwdata;
      #1;
   endtask

   initial begin
      compare_count  = 0;
      mismatch_count = 0;
      rst       = 1'b0;
      if_flush  = 1'b0;
      mem_rdata = '0;
      mem_done  = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_if_valid", if_valid, 0);
      checkOutput("rst_dm_valid", dm_valid, 0);
      checkOutput("rst_err", err, 0);
      nextCycle();
      rst = 1'b1;
      nextCycle();

      // Fetch only, done three cycles after issue; address change in BUSY is ignored
      applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
      checkOutput("f_mem_en", mem_en, 1);
      checkOutput("f_mem_addr", mem_addr, 16'h0010);
      checkOutput("f_mem_wr", mem_wr, 0);
      checkOutput("f_stall_issue", if_stall, 1);
      nextCycle();
      applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0, '0, '0);
      checkOutput("f_busy_mem_en", mem_en, 0);
      checkOutput("f_busy_addr_latched", mem_addr, 16'h0010);
      checkOutput("f_busy_stall", if_stall, 1);
      nextCycle();
      nextCycle();
      mem_done = 1'b1; mem_rdata = 16'hA5A5; #1;
      checkOutput("f_if_valid", if_valid, 1);
      checkOutput("f_if_rdata", if_rdata, 16'hA5A5);
      checkOutput("f_stall_done", if_stall, 0);
      nextCycle();
      mem_done = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("f_idle_mem_en", mem_en, 0);
      checkOutput("f_idle_if_valid", if_valid, 0);

      // Collision: data wins first, fetch issues in the IDLE cycle after dm_valid
      applyStimulus(1'b1, 16'h0080, 1'b1, 1'b1, 16'h0040, 16'h1234);
      checkOutput("c_mem_en", mem_en, 1);
      checkOutput("c_mem_wr", mem_wr, 1);
      checkOutput("c_mem_addr", mem_addr, 16'h0040);
      checkOutput("c_mem_wdata", mem_wdata, 16'h1234);
      nextCycle();
      mem_done = 1'b1; mem_rdata = 16'h0000; #1;
      checkOutput("c_dm_valid", dm_valid, 1);
      checkOutput("c_dm_stall", dm_stall, 0);
      checkOutput("c_if_valid", if_valid, 0);
      nextCycle();
      mem_done = 1'b0;
      applyStimulus(1'b1, 16'h0080, 1'b0, 1'b0, '0, '0);
      checkOutput("c_fetch_en", mem_en, 1);
      checkOutput("c_fetch_addr", mem_addr, 16'h0080);
      checkOutput("c_fetch_wr", mem_wr, 0);
      nextCycle();
      mem_done = 1'b1; mem_rdata = 16'h5555; #1;
      checkOutput("c_fetch_valid", if_valid, 1);
      checkOutput("c_fetch_rdata", if_rdata, 16'h5555);
      nextCycle();
      mem_done = 1'b0;

      // Starvation: four data grants, then a forced fetch, then data resumes
      applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0300, '0);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("s_en_%0d", k), mem_en, 1);
         checkOutput($sformatf("s_addr_%0d", k), mem_addr, (k == 4) ? 16'h0200 : 16'h0300);
         nextCycle();
         mem_done = 1'b1; mem_rdata = 16'h1000 + 16'(k); #1;
         checkOutput($sformatf("s_ivalid_%0d", k), if_valid, (k == 4) ? 1 : 0);
         checkOutput($sformatf("s_dvalid_%0d", k), dm_valid, (k == 4) ? 0 : 1);
         nextCycle();
         mem_done = 1'b0; #1;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      nextCycle();
      mem_done = 1'b1; nextCycle(); mem_done = 1'b0;
      rst = 1'b0; #1; rst = 1'b1; #1;

      // Flush in flight: stale completion dropped, new fetch issues right after
      applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, '0, '0);
      checkOutput("fl_en", mem_en, 1);
      checkOutput("fl_addr", mem_addr, 16'h0020);
      nextCycle();
      nextCycle();
      if_flush = 1'b1; #1;
      checkOutput("fl_flush_valid", if_valid, 0);
      nextCycle();
      if_flush = 1'b0;
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, '0, '0);
      checkOutput("fl_busy_en", mem_en, 0);
      mem_done = 1'b1; mem_rdata = 16'hFFFF; #1;
      checkOutput("fl_killed_valid", if_valid, 0);
      checkOutput("fl_killed_stall", if_stall, 1);
      nextCycle();
      mem_done = 1'b0; #1;
      checkOutput("fl_new_en", mem_en, 1);
      checkOutput("fl_new_addr", mem_addr, 16'h0100);
      nextCycle();
      mem_done = 1'b1; mem_rdata = 16'h0BAD; #1;
      checkOutput("fl_new_valid", if_valid, 1);
      checkOutput("fl_new_rdata", if_rdata, 16'h0BAD);
      nextCycle();
      mem_done = 1'b0;

      // Flush coincident with done, then flush in IDLE blocks fetch but not data
      applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, '0, '0);
      nextCycle();
      mem_done = 1'b1; if_flush = 1'b1; mem_rdata = 16'h3333; #1;
      checkOutput("fc_valid", if_valid, 0);
      checkOutput("fc_rdata", if_rdata, 0);
      nextCycle();
      mem_done = 1'b0; #1;
      checkOutput("fi_no_en", mem_en, 0);
      applyStimulus(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0044, '0);
      checkOutput("fi_data_en", mem_en, 1);
      checkOutput("fi_data_addr", mem_addr, 16'h0044);
      nextCycle();
      if_flush = 1'b0;
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0044, '0);
      mem_done = 1'b1; mem_rdata = 16'h4444; #1;
      checkOutput("fi_dm_valid", dm_valid, 1);
      checkOutput("fi_dm_rdata", dm_rdata, 16'h4444);
      nextCycle();
      mem_done = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

      // Spurious done in IDLE sets sticky err and yields no valid
      checkOutput("e_err_before", err, 0);
      mem_done = 1'b1; #1;
      checkOutput("e_no_ivalid", if_valid, 0);
      checkOutput("e_no_dvalid", dm_valid, 0);
      nextCycle();
      mem_done = 1'b0; #1;
      checkOutput("e_err_set", err, 1);
      nextCycle();
      nextCycle();
      checkOutput("e_err_sticky", err, 1);

      // Reset during BUSY_D clears everything; a late done afterwards sets err
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0050, 16'h7777);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("r_busy_addr", mem_addr, 16'h0050);
      checkOutput("r_busy_wr", mem_wr, 1);
      rst = 1'b0; #1;
      checkOutput("r_mem_addr", mem_addr, 0);
      checkOutput("r_mem_wr", mem_wr, 0);
      checkOutput("r_mem_wdata", mem_wdata, 0);
      checkOutput("r_mem_en", mem_en, 0);
      checkOutput("r_err", err, 0);
      nextCycle();
      rst = 1'b1;
      mem_done = 1'b1; #1;
      checkOutput("r_late_dvalid", dm_valid, 0);
      nextCycle();
      mem_done = 1'b0; #1;
      checkOutput("r_late_err", err, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported instruction/data memory backend between the fetch stage (read-only) and the memory stage (read/write).
- One access is outstanding at a time; the backend signals completion with a done pulse.
- Data accesses win by default. A starvation counter guarantees that fetch eventually gets the port.
- Drives per-requester stall and valid signals. Supports discarding an in-flight fetch when a branch redirect occurs.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_MAX, 4, consecutive lost arbitrations after which fetch gets forced priority (>=1)
CW, 3, starvation counter width; must hold STARVE_MAX

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; level, held until if_valid or flush
if_addr  in  AW  fetch address
if_flush  in  1  branch redirect; kill in-flight fetch
if_rdata  out  DW  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle fetch completion
if_stall  out  1  fetch must hold PC/IFID
dm_req  in  1  data request; level, held until dm_valid
dm_wr  in  1  1=write, 0=read
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_rdata  out  DW  read data, valid with dm_valid
dm_valid  out  1  one-cycle data completion
dm_stall  out  1  memory stage must hold
mem_en  out  1  one-cycle issue strobe to backend
mem_wr  out  1  write qualifier with mem_en
mem_addr  out  AW  backend address
mem_wdata  out  DW  backend write data
mem_rdata  in  DW  backend read data, valid with mem_done
mem_done  in  1  backend completion pulse, >=1 cycle after mem_en
err  out  1  sticky protocol error

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset (rst=0, async): state=IDLE, starve_cnt=0, kill=0, err=0, latched addr/wdata/wr=0. All outputs are 0.
- IDLE, grant selection:
  - No request: stay in IDLE.
  - dm_req and not forced: grant data.
  - if_req and (no dm_req or starve_cnt==STARVE_MAX): grant fetch.
- IDLE with a grant (combinational):
  - mem_en=1; mem_addr/mem_wr/mem_wdata come from the granted requester (mem_wr=0 for fetch).
  - Next edge: latch addr/wr/wdata and go to BUSY_D or BUSY_I.
- BUSY_x: mem_en=0; mem_* driven from the latches; wait for mem_done.
- BUSY_D with mem_done: dm_valid=1 and dm_rdata=mem_rdata the same cycle (reads and writes both); next state IDLE.
- BUSY_I with mem_done: if_valid=(~kill & ~if_flush); if_rdata=mem_rdata; next state IDLE; kill cleared.
- Flush:
  - if_flush in BUSY_I sets kill.
  - if_flush in IDLE, or in the same cycle as a fetch grant: the grant is suppressed (no mem_en for fetch). Data may still be granted.
- Stall outputs: if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid (combinational).
- Back-to-back: after completion, the next issue happens in the following IDLE cycle. Minimum turnaround is 2 cycles per access.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each IDLE grant cycle where data wins while if_req=1.
  - Cleared on every fetch grant.
  - Unchanged otherwise.
- err:
  - Set on mem_done while IDLE; never cleared except by reset.
  - The spurious done produces no valid.
- Requester changes to addr/wdata while in BUSY are ignored (latched copy is used).
- Reset mid-access: everything returns to reset values. A mem_done arriving after reset deasserts in IDLE sets err.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0010, mem_done 3 cycles after mem_en with mem_rdata=0xA5A5 -> mem_en one cycle with addr 0x0010, mem_wr=0; if_valid pulse with if_rdata=0xA5A5; if_stall=1 until that cycle.
- Collision: if_req and dm_req (write, 0x0040, 0x1234) same cycle, starve_cnt=0 -> data granted first (mem_wr=1, mem_wdata=0x1234); fetch issued in the IDLE cycle after dm_valid; starve_cnt=1 then 0.
- Starvation: dm_req held continuously with immediate done, if_req=1 -> exactly 4 data grants, then a fetch grant, then data resumes.
- Flush in flight: fetch issued at 0x0020, if_flush pulsed during BUSY_I, done later with 0xFFFF -> if_valid stays 0, state returns to IDLE; a new fetch at 0x0100 issues next cycle.
- Flush coincident with done -> if_valid=0. Flush in IDLE with only if_req -> no mem_en.
- Protocol/reset: mem_done while IDLE -> err=1 and stays 1. Assert rst low during BUSY_D -> all outputs 0 immediately, err=0.
